// File: rtl/tensor_core_matmul_unit_if.sv
// Bus between the tensor-core register file and the 3x3 matrix-multiply unit.
// The master (register file side) supplies the start request and both operand
// matrices; the slave (multiply unit) returns status and the bulk write-back.
// Matrix elements are two's complement, DATA_WIDTH bits each, indexed
// [matrix][row][column] with matrix 0 = A / C and matrix 1 = B.
interface tensor_core_matmul_unit_if #(
   parameter int DATA_WIDTH = 8
);
   logic                                    start_in;
   logic [1:0][2:0][2:0][DATA_WIDTH-1:0]    operands_in;
   logic                                    busy_out;
   logic                                    done_out;
   logic                                    overflow_out;
   logic                                    bulk_write_enable_out;
   logic [1:0][2:0][2:0][DATA_WIDTH-1:0]    bulk_write_data_out;

   modport master (
      output start_in,
      output operands_in,
      input  busy_out,
      input  done_out,
      input  overflow_out,
      input  bulk_write_enable_out,
      input  bulk_write_data_out
   );

   modport slave (
      input  start_in,
      input  operands_in,
      output busy_out,
      output done_out,
      output overflow_out,
      output bulk_write_enable_out,
      output bulk_write_data_out
   );
endinterface

// File: rtl/tensor_core_matmul_unit.sv
// Sequential 3x3 signed matrix-multiply engine.
// Captures A and B from the register file bulk read port when a start is
// accepted, accumulates one column of A against one row of B per cycle for
// three cycles, then narrows the full-width sums and strobes C (into matrix 0)
// and the captured B (into matrix 1) back to the register file for chaining.
// Every output comes straight from a register.
module tensor_core_matmul_unit #(
   parameter int DATA_WIDTH = 8,
   parameter int ACC_WIDTH  = 18,
   parameter int SATURATE   = 0
) (
   input  logic                          clock_in,
   input  logic                          reset_in,
   tensor_core_matmul_unit_if.slave      bus
);

   localparam int C_EXT = ACC_WIDTH - DATA_WIDTH;

   typedef logic [2:0][2:0][DATA_WIDTH-1:0] mat_t;
   typedef logic [2:0][2:0][ACC_WIDTH-1:0]  acc_mat_t;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_MAC   = 2'd1,
      ST_WRITE = 2'd2
   } state_t;

   // True when a full-width sum cannot be represented in DATA_WIDTH bits:
   // the bits from the narrow sign bit upward must all match.
   function automatic logic f_out_of_range(input logic [ACC_WIDTH-1:0] s);
      logic [C_EXT:0] top;
      top = s[ACC_WIDTH-1:DATA_WIDTH-1];
      return !((&top) || (~|top));
   endfunction

   // Narrow one full-width sum: keep the low bits, or clamp when saturating.
   function automatic logic [DATA_WIDTH-1:0] f_narrow(input logic [ACC_WIDTH-1:0] s);
      logic [DATA_WIDTH-1:0] res;
      if ((SATURATE != 0) && f_out_of_range(s)) begin
         if (s[ACC_WIDTH-1]) begin
            res = {1'b1, {(DATA_WIDTH-1){1'b0}}};
         end else begin
            res = {1'b0, {(DATA_WIDTH-1){1'b1}}};
         end
      end else begin
         res = s[DATA_WIDTH-1:0];
      end
      return res;
   endfunction

   state_t     r_state;
   state_t     w_state_next;
   logic [1:0] r_k;
   mat_t       r_a;
   mat_t       r_b;
   acc_mat_t   r_acc;
   acc_mat_t   w_sum;
   mat_t       w_narrow;
   logic       w_ovf_any;
   logic [ACC_WIDTH-1:0] w_a_ext;
   logic [ACC_WIDTH-1:0] w_b_ext;
   logic [ACC_WIDTH-1:0] w_prod;
   logic       w_start_accept;
   logic       w_last_mac;

   logic                                  r_busy;
   logic                                  r_done;
   logic                                  r_we;
   logic                                  r_ovf;
   logic [1:0][2:0][2:0][DATA_WIDTH-1:0]  r_wdata;

   // State register; reset returns to IDLE regardless of the current state.
   always_ff @(posedge clock_in) begin
      if (reset_in) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   // Next-state logic: start is only honoured in IDLE, MAC lasts three
   // cycles (k = 0..2) and WRITE is a single cycle.
   always_comb begin
      w_state_next   = r_state;
      w_start_accept = 1'b0;
      w_last_mac     = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (bus.start_in) begin
               w_start_accept = 1'b1;
               w_state_next   = ST_MAC;
            end else begin
               w_state_next   = ST_IDLE;
            end
         end
         ST_MAC: begin
            if (r_k == 2'd2) begin
               w_last_mac   = 1'b1;
               w_state_next = ST_WRITE;
            end else begin
               w_state_next = ST_MAC;
            end
         end
         ST_WRITE: begin
            w_state_next = ST_IDLE;
         end
         default: begin
            w_state_next = ST_IDLE;
         end
      endcase
   end

   // Multiply-accumulate step for the current k, plus narrowing of the
   // resulting sums (only used on the last step, when they are final).
   always_comb begin
      w_sum     = '0;
      w_narrow  = '0;
      w_ovf_any = 1'b0;
      w_a_ext   = '0;
      w_b_ext   = '0;
      w_prod    = '0;
      for (int i = 0; i < 3; i++) begin
         for (int j = 0; j < 3; j++) begin
            w_a_ext     = {{C_EXT{r_a[i][r_k][DATA_WIDTH-1]}}, r_a[i][r_k]};
            w_b_ext     = {{C_EXT{r_b[r_k][j][DATA_WIDTH-1]}}, r_b[r_k][j]};
            w_prod      = w_a_ext * w_b_ext;
            w_sum[i][j] = r_acc[i][j] + w_prod;
            w_narrow[i][j] = f_narrow(w_sum[i][j]);
            w_ovf_any   = w_ovf_any | f_out_of_range(w_sum[i][j]);
         end
      end
   end

   // Datapath and output registers: capture on start, accumulate in MAC,
   // register the write-back on the last MAC edge, drop the strobe after WRITE.
   always_ff @(posedge clock_in) begin
      if (reset_in) begin
         r_k     <= 2'd0;
         r_a     <= '0;
         r_b     <= '0;
         r_acc   <= '0;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
         r_we    <= 1'b0;
         r_ovf   <= 1'b0;
         r_wdata <= '0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (w_start_accept) begin
                  r_a    <= bus.operands_in[0];
                  r_b    <= bus.operands_in[1];
                  r_acc  <= '0;
                  r_k    <= 2'd0;
                  r_ovf  <= 1'b0;
                  r_busy <= 1'b1;
               end else begin
                  r_busy <= 1'b0;
               end
               r_done <= 1'b0;
               r_we   <= 1'b0;
            end
            ST_MAC: begin
               r_acc <= w_sum;
               if (w_last_mac) begin
                  r_k     <= 2'd0;
                  r_wdata <= {r_b, w_narrow};
                  r_ovf   <= w_ovf_any;
                  r_we    <= 1'b1;
                  r_done  <= 1'b1;
               end else begin
                  r_k     <= r_k + 2'd1;
                  r_we    <= 1'b0;
                  r_done  <= 1'b0;
               end
               r_busy <= 1'b1;
            end
            ST_WRITE: begin
               r_we   <= 1'b0;
               r_done <= 1'b0;
               r_busy <= 1'b0;
            end
            default: begin
               r_we   <= 1'b0;
               r_done <= 1'b0;
               r_busy <= 1'b0;
               r_k    <= 2'd0;
            end
         endcase
      end
   end

   assign bus.busy_out              = r_busy;
   assign bus.done_out              = r_done;
   assign bus.overflow_out          = r_ovf;
   assign bus.bulk_write_enable_out = r_we;
   assign bus.bulk_write_data_out   = r_wdata;

endmodule

// File: doc/tensor_core_matmul_unit.md
Name: tensor_core_matmul_unit

Overview:
- Sequential 3x3 signed 8-bit matrix-multiply engine.
- Sits directly downstream of the tensor-core register file and reads both operand matrices from its bulk read port in one cycle: A = matrix 0, B = matrix 1.
- Computes C = A x B over three multiply-accumulate cycles.
- Drives the register file's bulk write port: C goes back into matrix 0 and B is retained in matrix 1, so the result can be chained into the next multiply.

Parameters:
- DATA_WIDTH, 8, element width in bits (signed two's complement).
- ACC_WIDTH, 18, accumulator width; fits 3 products of DATA_WIDTH x DATA_WIDTH plus sign growth.
- SATURATE, 0, result narrowing mode: 0 = wrap (keep low DATA_WIDTH bits), 1 = clamp to [-128, 127].

Ports:
- clock_in  input  1  single clock; all state updates on its rising edge.
- reset_in  input  1  synchronous, active-high reset.
- start_in  input  1  request a multiply; sampled only in IDLE.
- operands_in  input  signed [DATA_WIDTH-1:0] [2][3][3]  bulk read data from the register file; [0] = A, [1] = B.
- busy_out  output  1  high while in MAC or WRITE.
- done_out  output  1  one-cycle pulse, coincident with bulk_write_enable_out.
- overflow_out  output  1  sticky for the current operation; valid when done_out = 1; held until the next accepted start.
- bulk_write_enable_out  output  1  one-cycle write strobe to the register file.
- bulk_write_data_out  output  signed [DATA_WIDTH-1:0] [2][3][3]  [0] = C (narrowed), [1] = captured B.

Behaviour:
- Reset (reset_in = 1 at an edge):
  - state goes to IDLE, k counter = 0.
  - All accumulators, captured operands and bulk_write_data_out are cleared to 0.
  - busy_out, done_out, overflow_out and bulk_write_enable_out go to 0.
  - Reset has priority over every other event, including mid-MAC and during WRITE; an aborted operation produces no write strobe.
- States: IDLE, MAC, WRITE.
- IDLE:
  - If start_in = 1 at edge E0: capture operands_in into internal A/B registers, clear all 9 accumulators, clear overflow, set k = 0, go to MAC.
  - Otherwise remain in IDLE and hold all outputs.
- MAC (three edges, E1 to E3):
  - At each edge, for every i, j: acc[i][j] += sext(A[i][k]) * sext(B[k][j]), computed at ACC_WIDTH.
  - k increments after each edge. When k = 2 completes (E3), go to WRITE.
  - The same edge also registers bulk_write_data_out and overflow_out from the final sums.
- WRITE (the cycle between E3 and E4):
  - bulk_write_enable_out = 1 and done_out = 1 for exactly one cycle.
  - At E4 return to IDLE.
  - bulk_write_data_out holds its value after E4 until the next write or a reset.
- Latency:
  - Operand capture at E0; write strobe visible from E3 to E4.
  - Start-to-strobe is 3 cycles; 4 cycles from start acceptance until IDLE is re-entered.
  - The earliest next start is accepted at E4 + 1 (back-to-back throughput is one op per 4 cycles; no start is accepted at E4).
- busy_out is registered: 1 from after E0 through E4, 0 in IDLE.
- start_in while busy is ignored and not queued.
- Operands are captured only at E0. Changes on operands_in during MAC, including the register file being rewritten by another master, do not affect the result.
- Narrowing (per element):
  - Overflow is flagged if the final ACC_WIDTH sum lies outside [-128, 127]; overflow_out is the OR over all 9 elements.
  - SATURATE = 0: output the low 8 bits.
  - SATURATE = 1: clamp to -128 or 127.
- Intermediate sums are never narrowed; only the final value is.
- No combinational path from any input to any output.

Test Plan:
- Reset behaviour: assert reset_in for 2 cycles, then release -> all outputs 0, busy_out 0, no write strobe.
- Identity multiply:
  - Stimulus: A = identity, B = [[1,2,3],[4,5,6],[7,8,9]], pulse start_in.
  - Required: busy_out rises next cycle; bulk_write_enable_out and done_out high for exactly 1 cycle, 3 cycles after start.
  - Required: C = B, bulk_write_data_out[1] = B, overflow_out = 0.
- Signed arithmetic:
  - Stimulus: A = all -2, B = all 3.
  - Required: every C element = -18 (0xEE), overflow_out = 0.
- Overflow, wrap mode: A = all 127, B = all 127, SATURATE = 0 -> each sum 48387 (0xBD03), C = 0x03, overflow_out = 1.
- Overflow, saturate mode: same stimulus with SATURATE = 1 -> C = 127 for all elements. A = all -128, B = all 127 -> C = -128.
- Busy, abort and chaining:
  - Operand isolation and busy: change operands_in and re-pulse start_in during MAC -> result uses the operands captured at E0; there is no second op.
  - Abort: reset_in at E2 -> no strobe, outputs 0, IDLE.
  - Chaining: a start at E4 + 1 after feeding C back -> correct second product.
